trace_stream_arbiter: RTL

TRACE_STREAM_ARBITER -- requirements
Module: trace_stream_arbiter

---
 rtl/trace_stream_arbiter_if.sv | 34 +++
 rtl/trace_stream_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/trace_stream_arbiter_if.sv
// Trace stream arbiter bus bundle.
//   trace_stream_arbiter_pkg : shared AXI stream beat width.
//   trace_stream_arbiter_if  : N AXI-stream trace sources (S_AXIS_*) plus the
//                              merged stream toward the DMA FIFO (M_AXIS_*).
//     modport slave  : arbiter view (consumes S_AXIS, produces M_AXIS)
//     modport master : environment view (produces S_AXIS, consumes M_AXIS)
package trace_stream_arbiter_pkg;
   localparam int AXI_DATA_WIDTH = 32;
endpackage

interface trace_stream_arbiter_if #(
   parameter int NUM_SOURCES = 2,
   parameter int DATA_WIDTH  = trace_stream_arbiter_pkg::AXI_DATA_WIDTH,
   parameter int ID_WIDTH    = 2
);
   logic [NUM_SOURCES-1:0]            S_AXIS_tvalid;
   logic [NUM_SOURCES-1:0]            S_AXIS_tready;
   logic [NUM_SOURCES*DATA_WIDTH-1:0] S_AXIS_tdata;
   logic [NUM_SOURCES-1:0]            S_AXIS_tlast;
   logic                              M_AXIS_tvalid;
   logic                              M_AXIS_tready;
   logic [DATA_WIDTH-1:0]             M_AXIS_tdata;
   logic                              M_AXIS_tlast;
   logic [ID_WIDTH-1:0]               M_AXIS_tid;

   modport slave (
      input  S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, M_AXIS_tready,
      output S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tlast, M_AXIS_tid
   );
   modport master (
      output S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, M_AXIS_tready,
      input  S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tlast, M_AXIS_tid
   );
endinterface

// File: rtl/trace_stream_arbiter.sv
// Trace stream arbiter: merges NUM_SOURCES AXI-stream trace sources into one
// stream, packet-locked round-robin with an optional per-grant burst limit.
// Ports:
//   clk            : single clock, rising edge
//   rst_n          : synchronous active-low reset
//   axis           : trace_stream_arbiter_if.slave (S_AXIS_* in, M_AXIS_* out)
//   source_enable  : mask for new grants (does not end a running grant)
//   max_burst      : beats per grant before forced release, 0 = unlimited
//   grant          : one-hot current owner, zero when idle
// Build option TRACE_STREAM_ARBITER_REGISTERED_OUTPUT_EN: M_AXIS driven from a
// one-entry output register (1-cycle latency) instead of a combinational mux.

// Per-source slice: request qualification, ready steering and AND-OR mux leg.
module trace_stream_arbiter_lane #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_valid,
   input  logic                  i_enable,
   input  logic                  i_grant,
   input  logic                  i_gnt_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_last,
   output logic                  o_req,
   output logic                  o_ready,
   output logic                  o_fire,
   output logic [DATA_WIDTH-1:0] o_data_m,
   output logic                  o_last_m
);
   assign o_req    = i_valid & i_enable;
   assign o_ready  = i_grant & i_gnt_ready;
   assign o_fire   = o_ready & i_valid;
   assign o_data_m = i_grant ? i_data : '0;
   assign o_last_m = i_grant & i_last;
endmodule

module trace_stream_arbiter #(
   parameter int NUM_SOURCES = 2,
   parameter int DATA_WIDTH  = trace_stream_arbiter_pkg::AXI_DATA_WIDTH,
   parameter int ID_WIDTH    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   trace_stream_arbiter_if.slave    axis,
   input  logic [NUM_SOURCES-1:0]   source_enable,
   input  logic [15:0]              max_burst,
   output logic [NUM_SOURCES-1:0]   grant
);
   localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t                 r_state;
   logic [IDX_W-1:0]       r_rr_ptr;
   logic [IDX_W-1:0]       r_gnt_idx;
   logic [15:0]            r_beat_cnt;
   logic [NUM_SOURCES-1:0] r_grant;

   logic [NUM_SOURCES-1:0]                 w_req;
   logic [NUM_SOURCES-1:0]                 w_ready;
   logic [NUM_SOURCES-1:0]                 w_fire;
   logic [NUM_SOURCES-1:0]                 w_last_m;
   logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] w_data_m;
   logic [DATA_WIDTH-1:0]                  w_data_sel;
   logic                                   w_last_sel;
   logic                                   w_acc;
   logic                                   w_release;
   logic                                   w_gnt_ready;
   logic                                   w_sel_found;
   logic [IDX_W-1:0]                       w_sel_idx;

   for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_lane
      trace_stream_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .i_valid     (axis.S_AXIS_tvalid[g]),
         .i_enable    (source_enable[g]),
         .i_grant     (r_grant[g]),
         .i_gnt_ready (w_gnt_ready),
         .i_data      (axis.S_AXIS_tdata[g*DATA_WIDTH +: DATA_WIDTH]),
         .i_last      (axis.S_AXIS_tlast[g]),
         .o_req       (w_req[g]),
         .o_ready     (w_ready[g]),
         .o_fire      (w_fire[g]),
         .o_data_m    (w_data_m[g]),
         .o_last_m    (w_last_m[g])
      );
   end

   assign axis.S_AXIS_tready = w_ready;
   assign grant              = r_grant;

   // Grant is one-hot, so the per-lane masked legs can simply be OR-ed.
   always_comb begin
      w_data_sel = '0;
      for (int g = 0; g < NUM_SOURCES; g++) w_data_sel = w_data_sel | w_data_m[g];
   end
   assign w_last_sel = |w_last_m;
   assign w_acc      = |w_fire;

   // Round-robin search starting just after the last packet's owner.
   always_comb begin
      int cand;
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      cand        = 0;
      for (int k = 1; k <= NUM_SOURCES; k++) begin
         cand = (int'(r_rr_ptr) + k) % NUM_SOURCES;
         if (!w_sel_found && w_req[cand[IDX_W-1:0]]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // tlast and the burst limit share one release path, so a coinciding
   // pair releases exactly once.
   assign w_release = w_acc &
                      (w_last_sel | ((max_burst != 16'd0) && (r_beat_cnt + 16'd1 == max_burst)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= IDX_W'(NUM_SOURCES - 1);
         r_gnt_idx  <= '0;
         r_beat_cnt <= '0;
         r_grant    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_sel_found) begin
                  r_state    <= ST_LOCKED;
                  r_gnt_idx  <= w_sel_idx;
                  r_grant    <= NUM_SOURCES'(1) << w_sel_idx;
                  r_beat_cnt <= '0;
               end
            end
            ST_LOCKED: begin
               // source_enable and tvalid gaps are deliberately ignored here:
               // only a released beat ends the grant.
               if (w_acc) begin
                  r_beat_cnt <= r_beat_cnt + 16'd1;
                  if (w_release) begin
                     r_state  <= ST_IDLE;
                     r_grant  <= '0;
                     r_rr_ptr <= r_gnt_idx;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef TRACE_STREAM_ARBITER_REGISTERED_OUTPUT_EN
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_last;
   logic [ID_WIDTH-1:0]   r_out_id;

   // Skid-free one-entry stage: refill in the same cycle it drains.
   assign w_gnt_ready = ~r_out_valid | axis.M_AXIS_tready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_id    <= '0;
      end else if (w_acc) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_data_sel;
         r_out_last  <= w_last_sel;
         r_out_id    <= ID_WIDTH'(r_gnt_idx);
      end else if (axis.M_AXIS_tready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign axis.M_AXIS_tvalid = r_out_valid;
   assign axis.M_AXIS_tdata  = r_out_data;
   assign axis.M_AXIS_tlast  = r_out_last;
   assign axis.M_AXIS_tid    = r_out_id;
`else
   assign w_gnt_ready        = axis.M_AXIS_tready;
   assign axis.M_AXIS_tvalid = |(axis.S_AXIS_tvalid & r_grant);
   assign axis.M_AXIS_tdata  = w_data_sel;
   assign axis.M_AXIS_tlast  = w_last_sel;
   assign axis.M_AXIS_tid    = (r_state == ST_LOCKED) ? ID_WIDTH'(r_gnt_idx) : '0;
`endif

endmodule
